mux_arb_n: RTL and testbench
============================

MUX_ARB_N -- requirements
Module: mux_arb_n

Interface
REQ-001 Parameter N, default 8, number of input channels (legal 2..16).
REQ-002 Parameter W, default 8, data width per channel (legal 1..64).
REQ-003 Derived constant SW = clog2(N), select/channel-index width; not overridable.
REQ-004 clk  input  1  the only clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 mode  input  1  0 = fixed select, 1 = round-robin arbitration.
REQ-007 sel  input  SW  channel index used in fixed mode.
REQ-008 in_valid  input  N  per-channel data-valid.
REQ-009 in_data  input  N*W  packed channel data; channel k occupies bits [k*W +: W].
REQ-010 in_ready  output  N  per-channel accept strobe; at most one bit high.
REQ-011 out_valid  output  1  output register holds a word.
REQ-012 out_data  output  W  registered data word.
REQ-013 out_ch  output  SW  index of the channel that supplied out_data.
REQ-014 out_ready  input  1  downstream accepts the word when high with out_valid.
REQ-015 xfer_cnt  output  16  transfer counter; present only under MUX_ARB_STATS_EN.

Function
REQ-016 Two-state output FSM: EMPTY (out_valid=0), FULL (out_valid=1).
REQ-017 load_en = EMPTY or (FULL and out_ready); the block SHALL sustain one transfer per cycle.
REQ-018 Fixed mode: grant = sel when sel < N and in_valid[sel]=1; otherwise no grant.
REQ-019 Round-robin mode: grant = first channel k with in_valid[k]=1, searching ptr, ptr+1, ... wrapping modulo N.
REQ-020 After a round-robin transfer from channel g, ptr SHALL become (g+1) mod N; ptr unchanged in fixed mode or with no grant.
REQ-021 in_ready[g] = load_en and grant valid, combinational; all other in_ready bits 0.
REQ-022 On transfer: out_data <= channel g data, out_ch <= g, state FULL; zero-cycle bypass forbidden (latency exactly 1 cycle).
REQ-023 FULL with out_ready=1 and no grant: state EMPTY next cycle; out_data/out_ch hold last values.
REQ-024 FULL with out_ready=0: out_data, out_ch, out_valid SHALL remain stable; all in_ready 0.
REQ-025 mode or sel changes take effect for the grant computed in the same cycle; a word already in the output register is unaffected.
REQ-026 sel >= N (non-power-of-two N): no grant, no error, no state change beyond draining.

Reset
REQ-027 While rst=1: out_valid=0, out_data=0, out_ch=0, ptr=0, state EMPTY, xfer_cnt=0, in_ready all 0.
REQ-028 Reset mid-transfer SHALL discard the held word; first grant possible on the cycle after rst deasserts.

Configuration
REQ-029 Macro MUX_ARB_STATS_EN defined: xfer_cnt increments by 1 on each output handshake (out_valid and out_ready), saturating at 16'hFFFF.
REQ-030 Macro undefined: xfer_cnt port and counter logic SHALL be absent; all other behaviour identical.

Structure
REQ-031 Shared package mux_pkg SHALL hold the mode encodings (MODE_FIXED=0, MODE_RR=1) and the FSM state encodings.
REQ-032 Round-robin priority search SHALL be a sub-module rr_pick (inputs req[N], ptr; outputs grant index, grant valid).

Verification
REQ-033 N=8,W=8, mode=0, sel=3, in_valid=8'h08, in_data ch3=8'hA5, out_ready=1 -> next cycle out_valid=1, out_data=8'hA5, out_ch=3, in_ready=8'h08 in request cycle.
REQ-034 mode=1, in_valid=8'hFF held, out_ready=1, ptr=0 after reset -> out_ch sequence 0,1,...,7,0 on consecutive cycles.
REQ-035 mode=1, in_valid=8'h81, ptr=0 -> grants ch0 then ch7 then ch0; ptr wraps 7->0.
REQ-036 FULL with out_data=8'h3C, out_ready=0 for 4 cycles -> out_data stays 8'h3C, in_ready=0; out_ready=1 -> new word next cycle.
REQ-037 rst asserted while FULL -> next cycle out_valid=0, out_data=0, ptr=0; with MUX_ARB_STATS_EN, xfer_cnt=0.
REQ-038 MUX_ARB_STATS_EN, xfer_cnt preloaded near 16'hFFFE by 3 handshakes -> reads 16'hFFFF and saturates.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared encodings for the mux_arb_n output stage: channel-select modes and
// output-register FSM states.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority search: returns the first requesting channel found
// when scanning from ptr upward, wrapping modulo N.
module rr_pick #(
    parameter  int N  = 8,
    localparam int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [SW-1:0] grant_idx,
    output logic          grant_vld
);

    // Scan from the far end back toward ptr so the closest requester wins last.
    always_comb begin
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % N]) begin
                grant_idx = SW'((int'(ptr) + i) % N);
                grant_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_arb_n.sv
// N-channel mux/arbiter feeding a single registered output word with
// valid/ready handshake. Optional transfer counter under MUX_ARB_STATS_EN.
module mux_arb_n
    import mux_pkg::*;
#(
    parameter  int N  = 8,
    parameter  int W  = 8,
    localparam int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    output logic [N-1:0]   in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_ch,
    input  logic           out_ready
`ifdef MUX_ARB_STATS_EN
    ,
    output logic [15:0]    xfer_cnt
`endif
);

    state_e        state_q, state_d;
    logic [W-1:0]  data_q, data_d;
    logic [SW-1:0] ch_q, ch_d;
    logic [SW-1:0] ptr_q, ptr_d;

    logic [SW-1:0] rr_idx;
    logic          rr_vld;
    logic          fix_vld;
    logic [SW-1:0] grant_idx;
    logic          grant_vld;
    logic          load_en;
    logic          take;

    rr_pick #(.N(N)) u_rr_pick (
        .req       (in_valid),
        .ptr       (ptr_q),
        .grant_idx (rr_idx),
        .grant_vld (rr_vld)
    );

    always_comb begin
        // sel may exceed N-1 when N is not a power of two; such a select never grants.
        fix_vld   = (int'(sel) < N) && in_valid[sel];
        grant_idx = (mode == MODE_RR) ? rr_idx : sel;
        grant_vld = (mode == MODE_RR) ? rr_vld : fix_vld;
        load_en   = (state_q == ST_EMPTY) || out_ready;
        take      = !rst && load_en && grant_vld;
        in_ready  = take ? (N'(1) << grant_idx) : '0;

        state_d = state_q;
        data_d  = data_q;
        ch_d    = ch_q;
        ptr_d   = ptr_q;
        if (take) begin
            state_d = ST_FULL;
            data_d  = in_data[int'(grant_idx)*W +: W];
            ch_d    = grant_idx;
            if (mode == MODE_RR) begin
                ptr_d = (int'(grant_idx) == N - 1) ? '0 : grant_idx + SW'(1);
            end
        end else if (state_q == ST_FULL && out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            ch_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            ptr_q   <= ptr_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;
    assign out_ch    = ch_q;

`ifdef MUX_ARB_STATS_EN
    logic [15:0] cnt_q, cnt_d;

    // Counts output handshakes, sticking at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_FULL && out_ready && cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mux_arb_n.sv
// Self-checking bench for mux_arb_n (N=8, W=8): behavioural model checked
// every cycle plus directed literal expectations.
module tb_mux_arb_n;

    localparam int N  = 8;
    localparam int W  = 8;
    localparam int SW = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           mode;
    logic [SW-1:0]  sel;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_ch;
    logic           out_ready;
`ifdef MUX_ARB_STATS_EN
    logic [15:0]    xfer_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;

    mux_arb_n #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
`ifdef MUX_ARB_STATS_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: which channel wins under the current inputs.
    function automatic int pick(input logic md, input int s, input logic [N-1:0] v, input int p);
        if (!md) return (s < N && v[s]) ? s : -1;
        for (int i = 0; i < N; i++) begin
            if (v[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    logic        m_vld  = 1'b0;
    logic [W-1:0] m_data = '0;
    int          m_ch   = 0;
    int          m_ptr  = 0;
    logic [15:0] m_cnt  = '0;
    int          m_g;
    logic        m_take;
    logic [N-1:0] m_rdy;

    always_comb begin
        m_g    = pick(mode, int'(sel), in_valid, m_ptr);
        m_take = !rst && (!m_vld || out_ready) && (m_g >= 0);
        m_rdy  = m_take ? (N'(1) << m_g) : '0;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_vld  <= 1'b0;
            m_data <= '0;
            m_ch   <= 0;
            m_ptr  <= 0;
            m_cnt  <= '0;
        end else begin
            if (m_vld && out_ready && m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
            if (m_take) begin
                m_vld  <= 1'b1;
                m_data <= in_data[m_g*W +: W];
                m_ch   <= m_g;
                if (mode) m_ptr <= (m_g + 1) % N;
            end else if (m_vld && out_ready) begin
                m_vld <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model out_valid", 64'(out_valid), 64'(m_vld));
            chk("model out_data", 64'(out_data), 64'(m_data));
            chk("model out_ch", 64'(out_ch), 64'(m_ch));
            chk("model in_ready", 64'(in_ready), 64'(m_rdy));
`ifdef MUX_ARB_STATS_EN
            chk("model xfer_cnt", 64'(xfer_cnt), 64'(m_cnt));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_ch(input int k, input logic [W-1:0] d);
        in_data[k*W +: W] = d;
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; in_data = '0; out_ready = 1'b0;
        for (int k = 0; k < N; k++) set_ch(k, W'(k * 17));
        tick(); tick();
        chk_en = 1'b1;
        in_valid = 8'hFF;
        #1;
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset out_data", 64'(out_data), 64'd0);
        chk("reset out_ch", 64'(out_ch), 64'd0);
        chk("reset in_ready", 64'(in_ready), 64'd0);

        // Fixed select of channel 3, first grant on the cycle after reset releases.
        tick();
        rst = 1'b0; mode = 1'b0; sel = 3'd3; in_valid = 8'h08; out_ready = 1'b1;
        set_ch(3, 8'hA5);
        #1;
        chk("fixed in_ready", 64'(in_ready), 64'h08);
        chk("fixed no bypass", 64'(out_valid), 64'd0);
        tick();
        in_valid = 8'h00;
        chk("fixed out_valid", 64'(out_valid), 64'd1);
        chk("fixed out_data", 64'(out_data), 64'hA5);
        chk("fixed out_ch", 64'(out_ch), 64'd3);
        tick();
        chk("drain out_valid", 64'(out_valid), 64'd0);
        chk("drain data hold", 64'(out_data), 64'hA5);

        // Round-robin with all channels requesting.
        set_ch(3, 8'h33);
        mode = 1'b1; in_valid = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("rr all out_ch", 64'(out_ch), 64'(i % N));
            chk("rr all out_data", 64'(out_data), 64'((i % N) * 17));
        end

        // Reset while holding a word.
        rst = 1'b1; in_valid = 8'h00;
        #1;
        chk("rst in_ready", 64'(in_ready), 64'd0);
        tick();
        chk("rst full out_valid", 64'(out_valid), 64'd0);
        chk("rst full out_data", 64'(out_data), 64'd0);
        chk("rst full out_ch", 64'(out_ch), 64'd0);
`ifdef MUX_ARB_STATS_EN
        chk("rst xfer_cnt", 64'(xfer_cnt), 64'd0);
`endif
        rst = 1'b0;

        // Sparse requests on channels 0 and 7: pointer wraps.
        in_valid = 8'h81;
        tick(); chk("rr wrap 1", 64'(out_ch), 64'd0);
        tick(); chk("rr wrap 2", 64'(out_ch), 64'd7);
        chk("rr wrap data", 64'(out_data), 64'h77);
        tick(); chk("rr wrap 3", 64'(out_ch), 64'd0);

        // Backpressure holds the word stable.
        mode = 1'b0; sel = 3'd2; in_valid = 8'h04; set_ch(2, 8'h3C);
        tick();
        chk("stall load", 64'(out_data), 64'h3C);
        out_ready = 1'b0; in_valid = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            chk("stall out_data", 64'(out_data), 64'h3C);
            chk("stall out_valid", 64'(out_valid), 64'd1);
            chk("stall in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1; sel = 3'd5;
        #1;
        chk("release in_ready", 64'(in_ready), 64'h20);
        tick();
        chk("release out_ch", 64'(out_ch), 64'd5);
        chk("release out_data", 64'(out_data), 64'h55);

        // Mixed traffic, model-checked every cycle.
        for (int i = 0; i < 300; i++) begin
            rst       = ($urandom_range(0, 39) == 0);
            mode      = 1'($urandom_range(0, 1));
            sel       = 3'($urandom_range(0, 7));
            in_valid  = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < N; k++) set_ch(k, 8'($urandom));
            tick();
        end

`ifdef MUX_ARB_STATS_EN
        rst = 1'b1; tick();
        rst = 1'b0; mode = 1'b1; in_valid = 8'hFF; out_ready = 1'b1;
        for (int i = 0; i < 65540; i++) tick();
        chk("xfer_cnt saturate", 64'(xfer_cnt), 64'hFFFF);
`endif

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
